rf_stream_reader: RTL and testbench

- Read-side DMA engine for the 16x8 register file.
- On a start pulse it walks a contiguous address range, drives the register file's combinational read port, and streams each byte out on a valid/ready interface.
- Used for register dumps to the test harness and for block-copy out of the register file.
- Sits beside the core datapath and owns read port A while busy; the core must hold off port-A reads whenever busy=1.

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_skid_fifo.sv | 68 ++++++
 rtl/rf_stream_reader.sv | 121 ++++++++++++
 tb/tb_rf_stream_reader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file read-stream engine.
package rf_pkg;
    localparam int RF_PW    = 4;
    localparam int RF_DEPTH = 2 ** RF_PW;

    typedef logic [RF_PW-1:0] rf_idx_t;
    typedef logic [7:0]       rf_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } rd_state_t;
endpackage

// File: rtl/rf_skid_fifo.sv
// Two-entry FIFO of {data, idx, last} that decouples register reads from the
// output stream; a push into a full FIFO is accepted only alongside a pop.
module rf_skid_fifo
    import rf_pkg::*;
#(
    parameter int iw = RF_PW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  rf_byte_t      in_data,
    input  logic [iw-1:0] in_idx,
    input  logic          in_last,
    output rf_byte_t      head_data,
    output logic [iw-1:0] head_idx,
    output logic          head_last,
    output logic          full,
    output logic          empty
);
    rf_byte_t      data_q [2];
    logic [iw-1:0] idx_q  [2];
    logic          last_q [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    cnt;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign head_data = data_q[rd_ptr];
    assign head_idx  = idx_q[rd_ptr];
    assign head_last = last_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                idx_q[i]  <= '0;
                last_q[i] <= 1'b0;
            end
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            // When full, push and pop share a slot: the pop frees it this edge.
            if (push_ok) begin
                data_q[wr_ptr] <= in_data;
                idx_q[wr_ptr]  <= in_idx;
                last_q[wr_ptr] <= in_last;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end
endmodule

// File: rtl/rf_stream_reader.sv
// Read-side DMA engine: walks a register range through read port A and streams
// each byte out; owns port A while busy.
module rf_stream_reader
    import rf_pkg::*;
#(
    parameter int pw = RF_PW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [pw-1:0] start_addr,
    input  logic [pw:0]   count,
    input  logic          abort,
    output logic [pw:0]   rf_rd_addr,
    input  logic [7:0]    rf_rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic [pw-1:0] out_idx,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output rd_state_t     dbg_state
);
    rd_state_t     state;
    rd_state_t     state_next;
    logic [pw-1:0] cur_idx;
    logic [pw:0]   remaining;
    logic          issue;
    logic          pop;
    logic          flush;
    logic          last_issue;
    rf_byte_t      head_data;
    logic [pw-1:0] head_idx;
    logic          head_last;
    logic          fifo_full;
    logic          fifo_empty;

    // Stream handshake: a beat moves on a cycle where out_valid && out_ready;
    // while out_valid is high and out_ready low the payload is held unchanged.
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign last_issue = (remaining == (pw+1)'(1));

    assign out_data  = out_valid ? head_data : '0;
    assign out_idx   = out_valid ? head_idx  : '0;
    assign out_last  = out_valid && head_last;
    assign busy      = (state == ISSUE) || (state == DRAIN);
    assign done      = (state == DONE);
    assign dbg_state = state;
    assign rf_rd_addr = (state == ISSUE) ? {1'b0, cur_idx} : '0;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    flush      = 1'b1;
                    state_next = DONE;
                end else begin
                    issue = !fifo_full || pop;
                    if (issue && last_issue) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    flush      = 1'b1;
                    state_next = DONE;
                end else if (fifo_empty || (pop && !fifo_full)) begin
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_idx   <= '0;
            remaining <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                cur_idx   <= start_addr;
                remaining <= count;
            end else if (issue) begin
                cur_idx   <= cur_idx + pw'(1);
                remaining <= remaining - (pw+1)'(1);
            end
        end
    end

    // Read data is captured on the same edge it is addressed, so a write landing
    // on that edge is not seen.
    rf_skid_fifo #(.iw(pw)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (issue),
        .pop       (pop),
        .in_data   (rf_rd_data),
        .in_idx    (cur_idx),
        .in_last   (last_issue),
        .head_data (head_data),
        .head_idx  (head_idx),
        .head_last (head_last),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
endmodule

// File: tb/tb_rf_stream_reader.sv
// Bench for rf_stream_reader: register-file model, directed and random
// transfers, and a scoreboard of expected {last, idx, data} beats.
module tb_rf_stream_reader;
    import rf_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] start_addr;
    logic [4:0] count;
    logic       abort;
    logic [4:0] rf_rd_addr;
    logic [7:0] rf_rd_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_idx;
    logic       out_last;
    logic       busy;
    logic       done;
    rd_state_t  dbg_state;

    always #5 clk = ~clk;

    rf_stream_reader #(.pw(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .abort      (abort),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // Register file: combinational read, write lands on the clock edge.
    logic [7:0] rf_mem [16];
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    always @(posedge clk) if (wr_en) rf_mem[wr_addr] <= wr_data;
    assign rf_rd_data = rf_mem[rf_rd_addr[3:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [12:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int beats = 0;
    int lasts = 0;
    int valids = 0;
    int done_cnt = 0;
    int last_cyc = -1;
    int done_cyc = -1;
    int start_cyc = 0;
    int ready_mode = 0;
    logic        hold_ok = 1'b0;
    logic [12:0] hold_pay = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        logic [12:0] pay;
        pay = {out_last, out_idx, out_data};
        chk("rd_addr_msb", 32'(rf_rd_addr[4]), 32'(0));
        if (hold_ok) begin
            chk("hold_valid", 32'(out_valid), 32'(1));
            chk("hold_payload", 32'(pay), 32'(hold_pay));
        end
        hold_ok  = out_valid && !out_ready && !abort && !reset;
        hold_pay = pay;
        if (out_valid) valids++;
        if (out_valid && out_ready) begin
            beats++;
            if (out_last) begin
                lasts++;
                last_cyc = cyc;
            end
            if (exp_q.size() == 0) chk("unexpected_beat", 32'(exp_q.size()), 32'(1));
            else chk("beat", 32'(pay), 32'(exp_q.pop_front()));
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (cyc % 3 == 0);
        endcase
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    // Expected beats: consecutive indices mod 16, data as currently stored.
    task automatic model_xfer(input logic [3:0] a, input logic [4:0] c);
        logic [3:0] ix;
        for (int k = 0; k < int'(c); k++) begin
            ix = 4'(int'(a) + k);
            exp_q.push_back({(k == int'(c) - 1), ix, rf_mem[ix]});
        end
    endtask

    task automatic issue_start(input logic [3:0] a, input logic [4:0] c);
        start = 1'b1;
        start_addr = a;
        count = c;
        start_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic start_xfer(input logic [3:0] a, input logic [4:0] c);
        model_xfer(a, c);
        issue_start(a, c);
    endtask

    task automatic wait_done(input int budget, input bit beats_exp);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) step();
        chk("done_seen", 32'(done_cnt - d0), 32'(1));
        if (beats_exp) chk("done_after_last", 32'(done_cyc - last_cyc), 32'(1));
        step();
        chk("busy_after", 32'(busy), 32'(0));
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int b0, l0, v0, d0, c;
        logic [3:0] a;
        bit found;
        reset = 1'b1; start = 1'b0; start_addr = '0; count = '0; abort = 1'b0;
        out_ready = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        step(); step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_rd_addr", 32'(rf_rd_addr), 32'(0));
        chk("rst_data", 32'(out_data), 32'(0));
        step();

        // Full sweep at full throughput.
        for (int i = 0; i < 16; i++) wr_reg(4'(i), 8'(16 + i));
        b0 = beats; l0 = lasts;
        start_xfer(4'd0, 5'd16);
        @(negedge clk);
        chk("lat_busy", 32'(busy), 32'(1));
        chk("lat_no_valid", 32'(out_valid), 32'(0));
        step();
        @(negedge clk);
        chk("lat_valid", 32'(out_valid), 32'(1));
        chk("lat_idx", 32'(out_idx), 32'(0));
        wait_done(100, 1);
        chk("sweep_beats", 32'(beats - b0), 32'(16));
        chk("sweep_lasts", 32'(lasts - l0), 32'(1));

        // Wrap-around range.
        b0 = beats;
        start_xfer(4'd14, 5'd4);
        wait_done(50, 1);
        chk("wrap_beats", 32'(beats - b0), 32'(4));

        // Zero-length request.
        v0 = valids;
        start_xfer(4'd5, 5'd0);
        wait_done(10, 0);
        chk("zero_done_cyc", 32'(done_cyc - start_cyc), 32'(1));
        chk("zero_no_valid", 32'(valids - v0), 32'(0));

        // Stalled downstream, ready pattern 1,0,0.
        ready_mode = 2; b0 = beats;
        start_xfer(4'd3, 5'd5);
        wait_done(100, 1);
        chk("stall_beats", 32'(beats - b0), 32'(5));
        ready_mode = 0;

        // Same-edge write to r3 is missed; earlier write to r7 is seen.
        model_xfer(4'd0, 5'd16);
        exp_q[7][7:0] = 8'hBB;
        issue_start(4'd0, 5'd16);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (rf_rd_addr == 5'd3) found = 1;
            else step();
        end
        chk("coh_found", 32'(found), 32'(1));
        wr_reg(4'd3, 8'hAA);
        wr_reg(4'd7, 8'hBB);
        wait_done(100, 1);

        // Abort in IDLE has no effect.
        abort = 1'b1; step(); abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_done", 32'(done), 32'(0));
        chk("idle_abort_busy", 32'(busy), 32'(0));
        step();

        // Abort during ISSUE after two accepted beats.
        b0 = beats; l0 = lasts; d0 = done_cnt;
        start_xfer(4'd0, 5'd8);
        for (int i = 0; i < 20 && beats - b0 < 2; i++) step();
        abort = 1'b1; step(); abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_valid", 32'(out_valid), 32'(0));
        chk("abort_done", 32'(done), 32'(1));
        step(); step();
        chk("abort_done_once", 32'(done_cnt - d0), 32'(1));
        chk("abort_no_last", 32'(lasts - l0), 32'(0));
        b0 = beats;
        start_xfer(4'd9, 5'd3);
        wait_done(50, 1);
        chk("post_abort_beats", 32'(beats - b0), 32'(3));

        // Random transfers; the first also pulses start while busy.
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 16; i++) wr_reg(4'(i), 8'($urandom_range(0, 255)));
            ready_mode = $urandom_range(0, 2);
            a = 4'($urandom_range(0, 15));
            c = $urandom_range(0, 16);
            if (j == 0 && c < 2) c = 2;
            b0 = beats;
            start_xfer(a, 5'(c));
            if (j == 0) begin
                step();
                start = 1'b1; start_addr = 4'd5; count = 5'd3;
                step();
                start = 1'b0;
            end
            wait_done(300, c != 0);
            chk("rand_beats", 32'(beats - b0), 32'(c));
        end

        // Reset in the middle of a transfer.
        ready_mode = 1;
        start_xfer(4'd0, 5'd10);
        repeat (4) step();
        reset = 1'b1; step();
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));
        chk("mid_rst_addr", 32'(rf_rd_addr), 32'(0));
        chk("mid_rst_payload", 32'({out_last, out_idx, out_data}), 32'(0));
        step();
        reset = 1'b0;
        ready_mode = 0; b0 = beats;
        start_xfer(4'd2, 5'd6);
        wait_done(50, 1);
        chk("post_rst_beats", 32'(beats - b0), 32'(6));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
